// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg: shared types and constants for the instruction fetch unit.
// Holds the NOP filler, JAL opcode, FSM states and the J-immediate decoder.
package ifu_fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [6:0]  OPC_JAL   = 7'b1101111;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    HOLD
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] j_imm(input logic [31:0] i);
    return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if: instruction-memory req/gnt/rvalid port.
// master = fetch unit, slave = memory.
interface ifu_fetch_if;

  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_gnt_i,
    input  imem_rvalid_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_gnt_i,
    output imem_rvalid_i,
    output imem_rdata_i
  );

endinterface

// File: rtl/ifu_fetch_fifo.sv
// ifu_fetch_fifo: in-order fetch buffer of {addr, instr} entries.
// Synchronous clear wins over a same-cycle push.
module ifu_fetch_fifo
  import ifu_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  fetch_entry_t           wdata,
  output fetch_entry_t           rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wp;
  logic [AW-1:0]  rp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (clear) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !clear) begin
      mem[wp] <= wdata;
    end
  end

  assign rdata = mem[rp];
  assign empty = (count == '0);

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: PC, imem fetch port, fetch buffer and decoder output register.
// Define IFU_STATIC_JAL_EN to redirect on a JAL delivered to the decoder.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = ifu_fetch_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst_n,
  ifu_fetch_if.master        imem,
  input  logic               stall_i,
  input  logic               flush_from_exe,
  input  logic [31:0]        flush_addr_exe,
  input  logic               flush_from_dec,
  input  logic [31:0]        flush_addr_dec,
  output logic [31:0]        instr_ifu_2_dec_o,
  output logic [31:0]        instr_addr_ifu_2_dec_o,
  output logic               instr_valid_o
);

  import ifu_fetch_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  typedef logic [CW-1:0] cnt_t;

  state_e       state_q, state_d;
  logic         req_q, req_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  tgt_q, tgt_d;
  logic [31:0]  rpc_q, rpc_d;
  cnt_t         out_q, out_d;
  cnt_t         disc_q, disc_d;
  cnt_t         fcnt, fcnt_nx, out_acc;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  iaddr_q, iaddr_d;
  logic         valid_q, valid_d;
  logic         gnt, rv, drop, acc;
  logic         flush, push, pop, clr, fempty;
  logic [31:0]  ftgt;
  fetch_entry_t head, wentry;
  logic         jal_fire;

`ifdef IFU_STATIC_JAL_EN
  logic         jal_q, jal_d;
  logic [31:0]  jtgt_q, jtgt_d;
  assign jal_fire = jal_q & ~stall_i;
`else
  assign jal_fire = 1'b0;
`endif

  assign gnt     = req_q & imem.imem_gnt_i;
  assign rv      = imem.imem_rvalid_i;
  assign drop    = rv & (disc_q != '0);
  assign acc     = rv & (disc_q == '0);
  assign out_acc = out_q + cnt_t'(gnt) - cnt_t'(rv);
  assign flush   = flush_from_exe | flush_from_dec | jal_fire;
  assign wentry  = {rpc_q, imem.imem_rdata_i};

  always_comb begin
    ftgt = '0;
    if (flush_from_exe)      ftgt = flush_addr_exe;
    else if (flush_from_dec) ftgt = flush_addr_dec;
`ifdef IFU_STATIC_JAL_EN
    else if (jal_fire)       ftgt = jtgt_q;
`endif
    ftgt[1:0] = 2'b00;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    rpc_d   = rpc_q;
    out_d   = out_acc;
    disc_d  = disc_q - cnt_t'(drop);
    instr_d = instr_q;
    iaddr_d = iaddr_q;
    valid_d = valid_q;
    push    = 1'b0;
    pop     = 1'b0;
    clr     = 1'b0;
`ifdef IFU_STATIC_JAL_EN
    jal_d   = jal_q & stall_i &
              ~(flush_from_exe | flush_from_dec);
    jtgt_d  = jtgt_q;
`endif

    unique case (state_q)
      BOOT: begin
        state_d = FETCH;
        if (flush) pc_d = ftgt;
      end
      FETCH: begin
        if (flush && req_q && !gnt) begin
          state_d = HOLD;
          tgt_d   = ftgt;
        end else if (flush) begin
          pc_d = ftgt;
        end else if (gnt) begin
          pc_d = pc_q + 32'd4;
        end
      end
      HOLD: begin
        if (flush) tgt_d = ftgt;
        // the held request was to a stale address
        if (gnt) begin
          state_d = FETCH;
          pc_d    = flush ? ftgt : tgt_q;
          disc_d  = disc_d + cnt_t'(1);
        end
      end
      default: state_d = BOOT;
    endcase

    if (flush) begin
      clr     = 1'b1;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      rpc_d   = ftgt;
      disc_d  = out_acc;
    end else begin
      if (acc) rpc_d = rpc_q + 32'd4;
      if (stall_i) begin
        push = acc;
      end else if (!fempty) begin
        pop     = 1'b1;
        push    = acc;
        instr_d = head.instr;
        iaddr_d = head.addr;
        valid_d = 1'b1;
      end else if (acc) begin
        // empty buffer: response goes straight to the output
        instr_d = imem.imem_rdata_i;
        iaddr_d = rpc_q;
        valid_d = 1'b1;
      end else begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
    end

`ifdef IFU_STATIC_JAL_EN
    if (!flush && !stall_i && valid_d &&
        instr_d[6:0] == OPC_JAL) begin
      jal_d  = 1'b1;
      jtgt_d = iaddr_d + j_imm(instr_d);
    end
`endif

    fcnt_nx = clr ? '0 : fcnt + cnt_t'(push) - cnt_t'(pop);
    req_d   = (state_d == HOLD) ||
              (state_d == FETCH &&
               ((state_q == FETCH && req_q && !gnt) ||
                (int'(fcnt_nx) + int'(out_d) < FIFO_DEPTH)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      req_q   <= 1'b0;
      pc_q    <= RESET_PC;
      tgt_q   <= RESET_PC;
      rpc_q   <= RESET_PC;
      out_q   <= '0;
      disc_q  <= '0;
      instr_q <= NOP_INSTR;
      iaddr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      rpc_q   <= rpc_d;
      out_q   <= out_d;
      disc_q  <= disc_d;
      instr_q <= instr_d;
      iaddr_q <= iaddr_d;
      valid_q <= valid_d;
    end
  end

`ifdef IFU_STATIC_JAL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      jal_q  <= 1'b0;
      jtgt_q <= '0;
    end else begin
      jal_q  <= jal_d;
      jtgt_q <= jtgt_d;
    end
  end
`endif

  ifu_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .clear (clr),
    .wdata (wentry),
    .rdata (head),
    .count (fcnt),
    .empty (fempty)
  );

  assign imem.imem_req_o     = req_q;
  assign imem.imem_addr_o    = pc_q;
  assign instr_ifu_2_dec_o      = instr_q;
  assign instr_addr_ifu_2_dec_o = iaddr_q;
  assign instr_valid_o          = valid_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed table and sequences for ifu_fetch.
// Memory returns addr ^ 32'hA5A5_0000, optionally a JAL +16 at 0x40.
module tb_ifu_fetch;

  localparam logic [31:0] K     = 32'hA5A5_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] JAL16 = 32'h0100_006F;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        fe = 1'b0;
  logic        fd = 1'b0;
  logic [31:0] fae = '0;
  logic [31:0] fad = '0;
  logic [31:0] instr, iaddr;
  logic        valid;
  logic        gnt_en = 1'b1;
  logic        rsp_en = 1'b1;
  logic        jal_en = 1'b0;
  int          total = 0;
  int          passed = 0;
  logic [31:0] q [$];

  ifu_fetch_if bus ();

  ifu_fetch #(
    .RESET_PC   (32'h0),
    .FIFO_DEPTH (2),
    .NOP_INSTR  (NOP)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .imem                   (bus),
    .stall_i                (stall),
    .flush_from_exe         (fe),
    .flush_addr_exe         (fae),
    .flush_from_dec         (fd),
    .flush_addr_dec         (fad),
    .instr_ifu_2_dec_o      (instr),
    .instr_addr_ifu_2_dec_o (iaddr),
    .instr_valid_o          (valid)
  );

  always #5 clk = ~clk;

  assign bus.imem_gnt_i = bus.imem_req_o & gnt_en;

  function automatic logic [31:0] word_at(input logic [31:0] a,
                                          input logic j);
    return (j && a == 32'h40) ? JAL16 : (a ^ K);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      bus.imem_rvalid_i <= 1'b0;
      bus.imem_rdata_i  <= '0;
    end else begin
      if (bus.imem_rvalid_i) void'(q.pop_front());
      if (bus.imem_req_o && bus.imem_gnt_i)
        q.push_back(bus.imem_addr_o);
      if (rsp_en && q.size() > 0) begin
        bus.imem_rvalid_i <= 1'b1;
        bus.imem_rdata_i  <= word_at(q[0], jal_en);
      end else begin
        bus.imem_rvalid_i <= 1'b0;
        bus.imem_rdata_i  <= '0;
      end
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    stall = 1'b0;
    fe = 1'b0;
    fd = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string name,
                            output logic [31:0] a,
                            output logic [31:0] ins);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!valid && n < 40);
    if (!valid) begin
      total++;
      $display("FAIL %s: no valid output in %0d cycles", name, n);
    end
    a = iaddr;
    ins = instr;
  endtask

  typedef struct {
    logic        stall;
    logic        v;
    logic [31:0] a;
    logic        req;
    logic [31:0] ia;
  } vec_t;

  vec_t tbl [16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, ins, ea;

    tbl[0]  = '{1'b0, 1'b0, 32'd0,  1'b0, 32'd0};
    tbl[1]  = '{1'b0, 1'b0, 32'd0,  1'b1, 32'd0};
    tbl[2]  = '{1'b0, 1'b0, 32'd0,  1'b1, 32'd4};
    tbl[3]  = '{1'b0, 1'b1, 32'd0,  1'b1, 32'd8};
    tbl[4]  = '{1'b0, 1'b1, 32'd4,  1'b1, 32'd12};
    tbl[5]  = '{1'b0, 1'b1, 32'd8,  1'b1, 32'd16};
    tbl[6]  = '{1'b1, 1'b1, 32'd12, 1'b1, 32'd20};
    tbl[7]  = '{1'b1, 1'b1, 32'd12, 1'b0, 32'd0};
    tbl[8]  = '{1'b1, 1'b1, 32'd12, 1'b0, 32'd0};
    tbl[9]  = '{1'b1, 1'b1, 32'd12, 1'b0, 32'd0};
    tbl[10] = '{1'b1, 1'b1, 32'd12, 1'b0, 32'd0};
    tbl[11] = '{1'b0, 1'b1, 32'd12, 1'b0, 32'd0};
    tbl[12] = '{1'b0, 1'b1, 32'd16, 1'b1, 32'd24};
    tbl[13] = '{1'b0, 1'b1, 32'd20, 1'b1, 32'd28};
    tbl[14] = '{1'b0, 1'b1, 32'd24, 1'b1, 32'd32};
    tbl[15] = '{1'b0, 1'b1, 32'd28, 1'b1, 32'd36};

    // stream from reset, with a 5-cycle stall
    do_reset();
    chk("reset imem_addr", bus.imem_addr_o, 32'h0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("c%0d valid", i), valid, tbl[i].v);
      chk($sformatf("c%0d addr", i), iaddr, tbl[i].a);
      chk($sformatf("c%0d instr", i), instr,
          tbl[i].v ? (tbl[i].a ^ K) : NOP);
      chk($sformatf("c%0d req", i), bus.imem_req_o, tbl[i].req);
      if (tbl[i].req)
        chk($sformatf("c%0d imem_addr", i), bus.imem_addr_o, tbl[i].ia);
      stall = tbl[i].stall;
      @(negedge clk);
    end
    stall = 1'b0;

    // flush with two responses outstanding
    rsp_en = 1'b0;
    do_reset();
    repeat (3) @(negedge clk);
    chk("A req off at 2 outstanding", bus.imem_req_o, 1'b0);
    fe = 1'b1;
    fae = 32'h100;
    @(negedge clk);
    fe = 1'b0;
    chk("A valid after flush", valid, 1'b0);
    rsp_en = 1'b1;
    wait_valid("A first", a, ins);
    chk("A first addr", a, 32'h100);
    chk("A first instr", ins, 32'h100 ^ K);
    wait_valid("A second", a, ins);
    chk("A second addr", a, 32'h104);

    // exe and dec flush together
    do_reset();
    repeat (6) @(negedge clk);
    fe = 1'b1;
    fae = 32'h200;
    fd = 1'b1;
    fad = 32'h300;
    @(negedge clk);
    fe = 1'b0;
    fd = 1'b0;
    chk("B valid after flush", valid, 1'b0);
    wait_valid("B first", a, ins);
    chk("B first addr", a, 32'h200);
    chk("B first instr", ins, 32'h200 ^ K);
    wait_valid("B second", a, ins);
    chk("B second addr", a, 32'h204);

    // flush during a withheld grant, misaligned target
    gnt_en = 1'b0;
    do_reset();
    @(negedge clk);
    chk("C req pending", bus.imem_req_o, 1'b1);
    fd = 1'b1;
    fad = 32'h83;
    @(negedge clk);
    fd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("C hold req %0d", i), bus.imem_req_o, 1'b1);
      chk($sformatf("C hold addr %0d", i), bus.imem_addr_o, 32'h0);
      @(negedge clk);
    end
    gnt_en = 1'b1;
    @(negedge clk);
    chk("C req after gnt", bus.imem_req_o, 1'b1);
    chk("C addr after gnt", bus.imem_addr_o, 32'h80);
    wait_valid("C first", a, ins);
    chk("C first addr", a, 32'h80);
    chk("C first instr", ins, 32'h80 ^ K);

    // JAL +16 at 0x40
    jal_en = 1'b1;
    do_reset();
    a = '0;
    for (int i = 0; i < 25 && a != 32'h40; i++)
      wait_valid("D scan", a, ins);
    chk("D jal addr", a, 32'h40);
    chk("D jal instr", ins, JAL16);
`ifdef IFU_STATIC_JAL_EN
    ea = 32'h50;
`else
    ea = 32'h44;
`endif
    wait_valid("D next", a, ins);
    chk("D next addr", a, ea);
    chk("D next instr", ins, ea ^ K);
    jal_en = 1'b0;

    // pc wrap at the top of the address space
    do_reset();
    repeat (4) @(negedge clk);
    fe = 1'b1;
    fae = 32'hFFFF_FFFC;
    @(negedge clk);
    fe = 1'b0;
    wait_valid("E top", a, ins);
    chk("E top addr", a, 32'hFFFF_FFFC);
    wait_valid("E wrap", a, ins);
    chk("E wrap addr", a, 32'h0);
    chk("E wrap instr", ins, K);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
